// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core req/gnt/rvalid port to APB3 initiator, one transfer in flight
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_gnt;
    logic                      w_done;
    logic                      w_timeout;
    logic                      r_rvalid;
    logic                      r_err;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;

    // Gate the grant with rst_n so every output reads 0 while reset is held.
    assign w_gnt  = rst_n && (r_state == S_IDLE) && req_i;
    assign w_done = (r_state == S_ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !pready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The cycle whose increment would reach TIMEOUT_CYCLES is the abort cycle.
    assign w_timeout = (r_state == S_ACCESS) && !pready && (r_cnt == CNT_LAST);
`else
    // No abort path; the comparison is constant false for any legal TIMEOUT_CYCLES.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_gnt) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_timeout) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (w_gnt) begin
            r_paddr  <= addr_i;
            r_pwrite <= we_i;
            r_pwdata <= we_i ? wdata_i : '0;
        end
    end

    // Response fields hold between pulses; only rvalid is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_done || w_timeout;
            if (w_done) begin
                r_rdata <= r_pwrite ? '0 : prdata;
                r_err   <= pslverr;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;
    assign pwrite   = r_pwrite;
    assign psel     = (r_state != S_IDLE);
    assign penable  = (r_state == S_ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_rv  = 0;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
        .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        resp_t r;
        r.rdata = d;
        r.err   = e;
        sb.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rvalid_o) begin
            n_rv++;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL stray_rvalid observed=rvalid expected=no_response_pending");
            end
            if (sb.size() > 0) begin
                resp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rdata_o, e.rdata);
                chk("rsp_err", {31'd0, err_o}, {31'd0, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single transfer with 'waits' wait states; core inputs are scrambled after grant.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int waits, input logic e, input logic [31:0] rd);
        step();
        req_i = 1'b1; addr_i = a; we_i = w; wdata_i = d;
        pready = 1'b0; pslverr = 1'b0; prdata = rd;
        #1;
        chk("gnt_idle", {31'd0, gnt_o}, 32'd1);
        push(w ? 32'd0 : rd, e);
        step();
        req_i = 1'b0; addr_i = ~a; we_i = ~w; wdata_i = ~d;
        chk("setup_psel", {30'd0, psel, penable}, 32'd2);
        chk("setup_rvalid", {31'd0, rvalid_o}, 32'd0);
        for (int i = 0; i <= waits; i++) begin
            step();
            if (i == waits) begin
                pready = 1'b1;
                pslverr = e;
            end
            chk("acc_pen", {30'd0, psel, penable}, 32'd3);
            chk("acc_paddr", paddr, a);
            chk("acc_pwrite", {31'd0, pwrite}, {31'd0, w});
            chk("acc_pwdata", pwdata, w ? d : 32'd0);
        end
        step();
        pready = 1'b0; pslverr = 1'b0;
        chk("done_psel", {30'd0, psel, penable}, 32'd0);
        chk("done_rvalid", {31'd0, rvalid_o}, 32'd1);
    endtask

    initial begin
        int rv0;
        rst_n = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        step();
        req_i = 1'b1;
        #1;
        chk("rst_outputs", {26'd0, gnt_o, rvalid_o, err_o, pwrite, psel, penable}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        req_i = 1'b0;
        step();
        rst_n = 1'b1;

        // Zero-wait write, 3-wait read, slave error then clean transfer.
        xfer(32'h1A10_1000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_5555);
        xfer(32'h1A10_3004, 1'b0, 32'h0, 3, 1'b0, 32'h0000_00A5);
        xfer(32'h1A10_2008, 1'b0, 32'h0, 1, 1'b1, 32'h1234_5678);
        xfer(32'h1A10_200C, 1'b1, 32'hCAFE_0001, 0, 1'b0, 32'h0);
        step();
        chk("idle_paddr_hold", paddr, 32'h1A10_200C);

        // Back-to-back writes with req_i held; grants land every third cycle.
        rv0 = n_rv;
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_i = 1'b1; we_i = 1'b1;
            addr_i = 32'h1A10_4000 + 32'(4 * k);
            wdata_i = 32'h100 + 32'(k);
            #1;
            chk("b2b_gnt", {31'd0, gnt_o}, 32'd1);
            if (k > 0) chk("b2b_rvalid", {31'd0, rvalid_o}, 32'd1);
            push(32'd0, 1'b0);
            step();
            addr_i = 32'hFFFF_FFFF; wdata_i = 32'h0;
            #1;
            chk("b2b_nogntA", {31'd0, gnt_o}, 32'd0);
            step();
            chk("b2b_nogntB", {31'd0, gnt_o}, 32'd0);
            chk("b2b_paddr", paddr, 32'h1A10_4000 + 32'(4 * k));
            chk("b2b_pwdata", pwdata, 32'h100 + 32'(k));
            if (k == 3) req_i = 1'b0;
            step();
        end
        pready = 1'b0;
        step();
        step();
        chk("b2b_rv_count", 32'(n_rv - rv0), 32'd4);

        // Reset asserted during ACCESS of a read: no response may follow.
        rv0 = n_rv;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_5000; prdata = 32'h77;
        step();
        req_i = 1'b0;
        step();
        chk("rst_acc_pen", {30'd0, psel, penable}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_acc_drop", {29'd0, psel, penable, rvalid_o}, 32'd0);
        step();
        rst_n = 1'b1;
        req_i = 1'b0;
        #1;
        chk("post_rst_gnt0", {31'd0, gnt_o}, 32'd0);
        req_i = 1'b1;
        #1;
        chk("post_rst_gnt1", {31'd0, gnt_o}, 32'd1);
        req_i = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        pready = 1'b0;
        chk("post_rst_norv", 32'(n_rv - rv0), 32'd0);

`ifdef APB_TIMEOUT_EN
        // Slave never answers: abort after 8 ACCESS cycles with an error response.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_6000; prdata = 32'hBAD0_BAD0;
        #1;
        chk("to_gnt", {31'd0, gnt_o}, 32'd1);
        push(32'd0, 1'b1);
        step();
        req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("to_acc_pen", {30'd0, psel, penable}, 32'd3);
        end
        step();
        chk("to_drop", {30'd0, psel, penable}, 32'd0);
        chk("to_rvalid", {31'd0, rvalid_o}, 32'd1);
        step();
`endif

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
